// File: rtl/lfsr_seq_core_if.sv
// Control/instruction bus of the LFSR sequencer: start/busy/halted handshake plus ROM fetch.
// Combinational wiring only; no latency, no backpressure.
interface lfsr_seq_core_if #(
    parameter int W  = 8,
    parameter int AW = 8
);
    logic          start;
    logic          busy;
    logic          halted;
    logic [AW-1:0] instr_addr;
    logic [W+5:0]  instr;

    modport master (output start, output instr, input busy, input halted, input instr_addr);
    modport slave  (input start, input instr, output busy, output halted, output instr_addr);
endinterface

// File: rtl/lfsr_seq_core.sv
// Instruction-driven W-bit LFSR pattern generator with pattern memory and HD accumulation.
// One instruction per cycle (RUN_N holds pc for N cycles); start is ignored while busy.
module lfsr_seq_core #(
    parameter int W     = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int ACCW  = 16,
    localparam int HDW  = $clog2(W + 1),
    localparam int RAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    lfsr_seq_core_if.slave  ctl,
    output logic [W-1:0]    Q,
    output logic [W-1:0]    Q_next,
    output logic [HDW-1:0]  hd,
    output logic [ACCW-1:0] hd_acc,
    output logic [RAW-1:0]  r_addr,
    output logic            lock
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RUNN, S_HALT} state_t;

    localparam logic [5:0] OP_CFG_TAP   = 6'h01;
    localparam logic [5:0] OP_INIT_L    = 6'h02;
    localparam logic [5:0] OP_RUN       = 6'h03;
    localparam logic [5:0] OP_STORE     = 6'h04;
    localparam logic [5:0] OP_LOAD      = 6'h05;
    localparam logic [5:0] OP_INIT_ADDR = 6'h06;
    localparam logic [5:0] OP_ADD_ADDR  = 6'h07;
    localparam logic [5:0] OP_SET_MODE  = 6'h08;
    localparam logic [5:0] OP_STORE_HD  = 6'h09;
    localparam logic [5:0] OP_RUN_N     = 6'h0A;
    localparam logic [5:0] OP_CLR_ACC   = 6'h0B;
    localparam logic [5:0] OP_HALT      = 6'h3F;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    tap_q, tap_d;
    logic            mode_q, mode_d;
    logic [RAW-1:0]  ra_q, ra_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [W-1:0]    cnt_q, cnt_d;

    logic [W-1:0]    mem [DEPTH];
    logic            mem_we;
    logic [W-1:0]    mem_wdat;

    logic [5:0]      opcode;
    logic [W-1:0]    operand;
    logic [W-1:0]    q_nx;
    logic [W-1:0]    q_diff;
    logic [HDW-1:0]  hd_c;
    logic [ACCW:0]   acc_sum;
    logic [ACCW-1:0] acc_sat;
    logic            step;

    assign opcode  = ctl.instr[W+5:W];
    assign operand = ctl.instr[W-1:0];

    // Galois feeds the MSB back into tapped positions; Fibonacci shifts in the tap parity.
    always_comb begin
        q_nx = {q_q[W-2:0], q_q[W-1]} ^ ({tap_q[W-1:1], 1'b0} & {W{q_q[W-1]}});
        if (mode_q) begin
            q_nx = {q_q[W-2:0], ^(tap_q & q_q)};
        end
    end

    assign q_diff = q_q ^ q_nx;

    always_comb begin
        hd_c = '0;
        for (int i = 0; i < W; i++) begin
            hd_c = hd_c + HDW'(q_diff[i]);
        end
    end

    assign acc_sum = {1'b0, acc_q} + (ACCW + 1)'(hd_c);
    assign acc_sat = acc_sum[ACCW] ? {ACCW{1'b1}} : acc_sum[ACCW-1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        q_d      = q_q;
        tap_d    = tap_q;
        mode_d   = mode_q;
        ra_d     = ra_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_wdat = q_q;
        step     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (ctl.start) begin
                    state_d = S_EXEC;
                    pc_d    = '0;
                end
            end
            S_EXEC: begin
                pc_d = pc_q + AW'(1);
                case (opcode)
                    OP_CFG_TAP:   tap_d  = operand;
                    OP_INIT_L:    q_d    = operand;
                    OP_RUN:       step   = 1'b1;
                    OP_STORE:     mem_we = 1'b1;
                    OP_LOAD:      q_d    = mem[ra_q];
                    OP_INIT_ADDR: ra_d   = operand[RAW-1:0];
                    OP_ADD_ADDR:  ra_d   = ra_q + operand[RAW-1:0];
                    OP_SET_MODE:  mode_d = operand[0];
                    OP_STORE_HD: begin
                        mem_we   = 1'b1;
                        mem_wdat = W'(hd_c);
                    end
                    OP_RUN_N: begin
                        if (operand != '0) begin
                            step = 1'b1;
                            if (operand != W'(1)) begin
                                state_d = S_RUNN;
                                cnt_d   = operand - W'(1);
                                pc_d    = pc_q;
                            end
                        end
                    end
                    OP_CLR_ACC:   acc_d  = '0;
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_RUNN: begin
                step  = 1'b1;
                cnt_d = cnt_q - W'(1);
                if (cnt_q == W'(1)) begin
                    state_d = S_EXEC;
                    pc_d    = pc_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (step) begin
            q_d   = q_nx;
            acc_d = acc_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            q_q     <= '0;
            tap_q   <= '0;
            mode_q  <= 1'b0;
            ra_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            q_q     <= q_d;
            tap_q   <= tap_d;
            mode_q  <= mode_d;
            ra_q    <= ra_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pattern memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ra_q] <= mem_wdat;
        end
    end

    assign Q              = q_q;
    assign Q_next         = q_nx;
    assign hd             = hd_c;
    assign hd_acc         = acc_q;
    assign r_addr         = ra_q;
    assign lock           = (q_q == '0);
    assign ctl.instr_addr = pc_q;
    assign ctl.busy       = (state_q == S_EXEC) || (state_q == S_RUNN);
    assign ctl.halted     = (state_q == S_HALT);
endmodule
